// File: rtl/div_cfg_ctrl.sv
// rtl/div_cfg_ctrl.sv - programmable clock divider with glitch-free ratio switching and run/stop control
module div_cfg_ctrl #(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             period_tick,
  output logic             clk_out
);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] p_q, p_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_p_q, clk_p_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clk_n_q;

  logic [DIV_W-1:0] n_m1;
  logic [DIV_W-1:0] l_m1;
  logic [DIV_W-1:0] cnt_next;
  logic             active;
  logic             at_end;
  logic             accept;
  logic             legal;

  // Period geometry: last count of the period and the count just before the high phase
  always_comb begin
    n_m1 = n_q - ONE;
    // (N+1)/2 - 1 equals N>>1 for odd N and (N>>1)-1 for even N; avoids a wider adder
    l_m1 = (n_q >> 1) - {{(DIV_W-1){1'b0}}, ~n_q[0]};
  end

  // Handshake and boundary decode shared by the state update and the outputs
  always_comb begin
    active    = (state_q != ST_OFF);
    at_end    = active && (cnt_q == n_m1);
    cfg_ready = (state_q == ST_OFF) || (state_q == ST_RUN);
    accept    = cfg_valid && cfg_ready;
    legal     = (cfg_div >= DIV_MIN);
    cnt_next  = at_end ? '0 : cnt_q + ONE;
  end

  // Next-state: ratio changes, starts and stops only ever land on a period boundary
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    clk_p_d = clk_p_q;
    done_d  = 1'b0;
    err_d   = accept && !legal;

    // High phase covers counts L..N-1 while the divider is running
    if (active) begin
      if (at_end) begin
        clk_p_d = 1'b0;
      end else if (cnt_q == l_m1) begin
        clk_p_d = 1'b1;
      end
    end

    case (state_q)
      ST_OFF: begin
        cnt_d   = '0;
        clk_p_d = 1'b0;
        if (accept && legal) begin
          n_d    = cfg_div;
          done_d = 1'b1;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_next;
        if (accept && legal) begin
          p_d     = cfg_div;
          state_d = ST_SWITCH;
        end else if (!en) begin
          // Dropping en in the final cycle of a period stops right at that boundary
          state_d = at_end ? ST_OFF : ST_STOP;
        end
      end
      ST_SWITCH: begin
        cnt_d = cnt_next;
        if (at_end) begin
          n_d     = p_q;
          done_d  = 1'b1;
          state_d = en ? ST_RUN : ST_OFF;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_next;
        if (en) begin
          state_d = ST_RUN;
        end else if (at_end) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
        clk_p_d = 1'b0;
      end
    endcase
  end

  // Posedge state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_OFF;
      n_q     <= DIV_RST_V;
      p_q     <= DIV_RST_V;
      cnt_q   <= '0;
      clk_p_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      clk_p_q <= clk_p_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Half-cycle extension for odd ratios; parity is captured with the sample so the
  // trailing half of the outgoing period follows the outgoing ratio across a switch
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_q & n_q[0];
    end
  end

  // Outputs
  always_comb begin
    cfg_done    = done_q;
    cfg_err     = err_q;
    period_tick = at_end;
    clk_out     = clk_p_q | clk_n_q;
  end

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// tb/tb_div_cfg_ctrl.sv - self-checking bench for div_cfg_ctrl
module tb_div_cfg_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_div = 4'd0;
  logic       cfg_ready, cfg_done, cfg_err, period_tick, clk_out;

  div_cfg_ctrl #(.DIV_W(4), .DIV_RST(5)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .period_tick(period_tick), .clk_out(clk_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       e, v;
    logic [3:0] d;
    logic       rdy, dn, er, tk, ck;
  } vec_t;

  vec_t tbl[17];
  int   n_vec = 0;
  int   n_miss = 0;
  int   tick_cnt = 0;
  int   hi_halves = 0;
  int   cyc = 0;

  // Reference: mode 0=off 1=run 2=switch 3=stop; waveform derived from period rules
  int m_mode, m_n, m_p, m_cnt;
  bit m_done, m_err, m_trail;

  function automatic vec_t mk(int e, int v, int d, int r, int dn, int er, int tk, int ck);
    vec_t t;
    t.e = 1'(e); t.v = 1'(v); t.d = 4'(d);
    t.rdy = 1'(r); t.dn = 1'(dn); t.er = 1'(er); t.tk = 1'(tk); t.ck = 1'(ck);
    return t;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 5; m_p = 5; m_cnt = 0;
    m_done = 0; m_err = 0; m_trail = 0;
  endtask

  function automatic bit m_high();
    return (m_mode != 0) && (m_cnt >= (m_n + 1) / 2);
  endfunction

  task automatic model_step(input logic e, input logic v, input int d);
    bit bnd, acc, lg;
    bnd = (m_mode != 0) && (m_cnt == m_n - 1);
    acc = v && (m_mode == 0 || m_mode == 1);
    lg  = (d >= 2);
    m_trail = bnd && (m_n % 2 == 1);
    m_done  = 0;
    m_err   = acc && !lg;
    case (m_mode)
      0: begin
        if (acc && lg) begin m_n = d; m_done = 1; end
        if (e) m_mode = 1;
        m_cnt = 0;
      end
      1: begin
        m_cnt = bnd ? 0 : m_cnt + 1;
        if (acc && lg) begin m_p = d; m_mode = 2; end
        else if (!e) m_mode = bnd ? 0 : 3;
      end
      2: begin
        if (bnd) begin
          m_n = m_p; m_cnt = 0; m_done = 1; m_mode = e ? 1 : 0;
        end else m_cnt = m_cnt + 1;
      end
      default: begin
        m_cnt = bnd ? 0 : m_cnt + 1;
        if (e) m_mode = 1;
        else if (bnd) m_mode = 0;
      end
    endcase
  endtask

  task automatic do_cycle(input logic e, input logic v, input logic [3:0] d, input int ti);
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge sys_clk);
    model_step(e, v, int'(d));
    cyc++;
    #1;
    chk("ready", cfg_ready, 1'(m_mode <= 1));
    chk("done", cfg_done, m_done);
    chk("err", cfg_err, m_err);
    chk("tick", period_tick, 1'((m_mode != 0) && (m_cnt == m_n - 1)));
    chk("clk_hi_half1", clk_out, m_high() | m_trail);
    chk("done_err_excl", cfg_done & cfg_err, 1'b0);
    if (ti >= 0) begin
      chk("tbl_ready", cfg_ready, tbl[ti].rdy);
      chk("tbl_done", cfg_done, tbl[ti].dn);
      chk("tbl_err", cfg_err, tbl[ti].er);
      chk("tbl_tick", period_tick, tbl[ti].tk);
      chk("tbl_clk", clk_out, tbl[ti].ck);
    end
    if (period_tick) tick_cnt++;
    if (clk_out) hi_halves++;
    @(negedge sys_clk);
    #1;
    chk("clk_hi_half2", clk_out, m_high());
    if (clk_out) hi_halves++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clk"}, clk_out, 1'b0);
    chk({tag, "_done"}, cfg_done, 1'b0);
    chk({tag, "_err"}, cfg_err, 1'b0);
    chk({tag, "_tick"}, period_tick, 1'b0);
    chk({tag, "_ready"}, cfg_ready, 1'b1);
  endtask

  initial begin
    int first_t, second_t;
    logic re, rv;
    logic [3:0] rd;

    // Directed table: N=5 run, illegal cfg, 5->4 switch, stop at boundary
    tbl[0]  = mk(0, 1, 0, 1, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 1, 1);
    tbl[6]  = mk(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[7]  = mk(1, 1, 1, 1, 0, 1, 0, 0);
    tbl[8]  = mk(1, 1, 4, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 1);
    tbl[11] = mk(1, 0, 0, 1, 1, 0, 0, 1);
    tbl[12] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 1, 1);
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 0, 0, 0);

    model_reset();
    #2;
    chk_reset_outputs("rst");
    #10;
    sys_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) do_cycle(tbl[i].e, tbl[i].v, tbl[i].d, i);

    // N=2: 1 high / 1 low
    do_cycle(1'b0, 1'b1, 4'd2, -1);
    tick_cnt = 0; hi_halves = 0;
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b0, 4'd0, -1);
    chk("n2_ticks", 1'(tick_cnt == 10), 1'b1);
    chk("n2_high_halves", 1'(hi_halves == 20), 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 4'd0, -1);

    // N=15: 7.5 cycles high, 15-cycle period
    do_cycle(1'b0, 1'b1, 4'd15, -1);
    tick_cnt = 0; hi_halves = 0;
    for (int i = 0; i < 30; i++) do_cycle(1'b1, 1'b0, 4'd0, -1);
    chk("n15_ticks", 1'(tick_cnt == 2), 1'b1);
    chk("n15_high_halves", 1'(hi_halves == 29), 1'b1);

    // Reset in the middle of a switch discards the pending ratio
    do_cycle(1'b1, 1'b1, 4'd7, -1);
    do_cycle(1'b1, 1'b0, 4'd0, -1);
    chk("in_switch_ready", cfg_ready, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_sw_rst");
    model_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    first_t = -1; second_t = -1;
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b1, 1'b0, 4'd0, -1);
      if (period_tick) begin
        if (first_t < 0) first_t = i;
        else if (second_t < 0) second_t = i;
      end
    end
    chk("post_rst_period5", 1'(second_t - first_t == 5 && first_t >= 0), 1'b1);

    // Randomized traffic against the reference
    re = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) re = ~re;
      rv = ($urandom_range(0, 7) == 0);
      rd = 4'($urandom_range(0, 15));
      do_cycle(re, rv, rd, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
